cellram_ctrl: RTL and testbench

//  Single-port controller between internal logic and an external Micron-style

---
 rtl/cellram_ctrl.sv | 167 ++++++++++++++++
 tb/tb_cellram_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/cellram_ctrl.sv
// Async-mode controller for a Micron-style CellRAM (PSRAM).
// Sequences CE#/OE#/WE#/LB#/UB# with fixed cycle counts and owns the DQ driver.
module cellram_ctrl #(
  parameter int RD_CYCLES  = 4,
  parameter int WR_CYCLES  = 4,
  parameter int REC_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic [23:0] cr__addr,
  input  logic [15:0] cr__data_in,
  input  logic        cr__read,
  input  logic        cr__write,
  output logic [15:0] cr__data_out,
  output logic        cr__wait,
  output logic [22:0] addr,
  output logic        adv_n,
  output logic        cre,
  output logic        ce_n,
  output logic        oe_n,
  output logic        we_n,
  output logic        lb_n,
  output logic        ub_n,
  inout  wire  [15:0] dq,
  input  logic        o_wait
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    HOLD,
    REC
  } state_e;

  localparam logic [7:0] RD_LAST  = 8'(RD_CYCLES - 1);
  localparam logic [7:0] WR_LAST  = 8'(WR_CYCLES - 1);
  localparam logic [7:0] REC_LAST = 8'(REC_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [22:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] dout_q, dout_d;
  logic        wait_q, wait_d;
  logic        ce_n_q, ce_n_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;
  logic        bytes_n_q, bytes_n_d;
  logic        dq_oe_q, dq_oe_d;

  // WAIT is only meaningful in sync burst mode; bit 0 of a word address is moot
  logic unused_ok;
  assign unused_ok = ^{o_wait, cr__addr[0]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    dout_d    = dout_q;
    wait_d    = wait_q;
    ce_n_d    = ce_n_q;
    oe_n_d    = oe_n_q;
    we_n_d    = we_n_q;
    bytes_n_d = bytes_n_q;
    dq_oe_d   = dq_oe_q;
    unique case (state_q)
      IDLE: begin
        if (cr__write || cr__read) begin
          addr_d    = cr__addr[23:1];
          wdata_d   = cr__data_in;
          wait_d    = 1'b1;
          ce_n_d    = 1'b0;
          bytes_n_d = 1'b0;
          cnt_d     = '0;
          if (cr__write) begin
            we_n_d  = 1'b0;
            dq_oe_d = 1'b1;
            state_d = WRITE;
          end else begin
            oe_n_d  = 1'b0;
            state_d = READ;
          end
        end
      end
      READ: begin
        if (cnt_q == RD_LAST) begin
          dout_d    = dq;
          oe_n_d    = 1'b1;
          ce_n_d    = 1'b1;
          bytes_n_d = 1'b1;
          cnt_d     = '0;
          state_d   = REC;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WRITE: begin
        if (cnt_q == WR_LAST) begin
          we_n_d    = 1'b1;
          ce_n_d    = 1'b1;
          bytes_n_d = 1'b1;
          state_d   = HOLD;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      // one extra cycle of DQ after WE# rises for data hold time
      HOLD: begin
        dq_oe_d = 1'b0;
        cnt_d   = '0;
        state_d = REC;
      end
      REC: begin
        if (cnt_q == REC_LAST) begin
          wait_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      dout_q    <= '0;
      wait_q    <= 1'b0;
      ce_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      bytes_n_q <= 1'b1;
      dq_oe_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      dout_q    <= dout_d;
      wait_q    <= wait_d;
      ce_n_q    <= ce_n_d;
      oe_n_q    <= oe_n_d;
      we_n_q    <= we_n_d;
      bytes_n_q <= bytes_n_d;
      dq_oe_q   <= dq_oe_d;
    end
  end

  assign dq           = dq_oe_q ? wdata_q : 16'hzzzz;
  assign cr__data_out = dout_q;
  assign cr__wait     = wait_q;
  assign addr         = addr_q;
  assign adv_n        = 1'b0;
  assign cre          = 1'b0;
  assign ce_n         = ce_n_q;
  assign oe_n         = oe_n_q;
  assign we_n         = we_n_q;
  assign lb_n         = bytes_n_q;
  assign ub_n         = bytes_n_q;

endmodule

// File: tb/tb_cellram_ctrl.sv
// Bench for cellram_ctrl: directed cases plus random traffic against
// a timeline model of each access and a word-array memory.
module tb_cellram_ctrl;

  localparam int RD  = 4;
  localparam int WR  = 4;
  localparam int REC = 1;

  logic        clk;
  logic        rst_b;
  logic [23:0] cr__addr;
  logic [15:0] cr__data_in;
  logic        cr__read;
  logic        cr__write;
  logic [15:0] cr__data_out;
  logic        cr__wait;
  logic [22:0] addr;
  logic        adv_n, cre, ce_n, oe_n, we_n, lb_n, ub_n;
  logic        o_wait;
  wire  [15:0] dq;

  cellram_ctrl #(
    .RD_CYCLES (RD),
    .WR_CYCLES (WR),
    .REC_CYCLES(REC)
  ) dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .cr__addr    (cr__addr),
    .cr__data_in (cr__data_in),
    .cr__read    (cr__read),
    .cr__write   (cr__write),
    .cr__data_out(cr__data_out),
    .cr__wait    (cr__wait),
    .addr        (addr),
    .adv_n       (adv_n),
    .cre         (cre),
    .ce_n        (ce_n),
    .oe_n        (oe_n),
    .we_n        (we_n),
    .lb_n        (lb_n),
    .ub_n        (ub_n),
    .dq          (dq),
    .o_wait      (o_wait)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // external PSRAM: 256 words, async read/write
  logic [15:0] ram [256] = '{default: 16'h0};
  assign dq = (!ce_n && !oe_n) ? ram[addr[7:0]] : 16'hzzzz;
  always @(negedge clk)
    if (!ce_n && !we_n) ram[addr[7:0]] <= dq;

  int ce_falls = 0;
  always @(negedge ce_n) ce_falls++;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference model
  logic [15:0] ref_mem [256] = '{default: 16'h0};
  int          busy_left = 0;
  int          t = 0;
  bit          op_wr = 0;
  logic [22:0] cur_addr = '0;
  logic [15:0] cur_data = '0;
  logic [15:0] exp_dout = '0;
  int          accepts = 0;

  task automatic check_outputs();
    bit act;
    bit strobe;
    act    = busy_left > 0;
    strobe = act && t < 4;
    chk("wait", cr__wait, act);
    chk("dout", cr__data_out, exp_dout);
    chk("ce_n", ce_n, !strobe);
    chk("we_n", we_n, !(strobe && op_wr));
    chk("oe_n", oe_n, !(strobe && !op_wr));
    chk("lb_ub", {lb_n, ub_n}, strobe ? 0 : 3);
    chk("adv_cre", {adv_n, cre}, 0);
    if (strobe) chk("addr", addr, cur_addr);
    if (act && op_wr && t < WR + 1)
      chk("dq_wr", dq, cur_data);
    else if (!(strobe && !op_wr))
      chk("dq_z", dq, 32'h0000_zzzz);
  endtask

  task automatic cycle(input bit rst, input bit rd, input bit wr,
                       input logic [23:0] a, input logic [15:0] d);
    rst_b       = rst;
    cr__read    = rd;
    cr__write   = wr;
    cr__addr    = a;
    cr__data_in = d;
    o_wait      = 1'($urandom);
    @(posedge clk);
    if (rst) begin
      busy_left = 0;
      exp_dout  = '0;
    end else if (busy_left > 0) begin
      busy_left--;
      t++;
      if (!op_wr && t == RD) exp_dout = ref_mem[cur_addr[7:0]];
    end else if (rd || wr) begin
      accepts++;
      cur_addr = a[23:1];
      cur_data = d;
      op_wr    = wr;
      t        = 0;
      if (wr) begin
        ref_mem[a[8:1]] = d;
        busy_left = WR + 1 + REC;
      end else begin
        busy_left = RD + REC;
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 24'h0, 16'h0);
  endtask

  initial begin
    int wait_hi;
    rst_b = 1'b1;
    cr__read = 0; cr__write = 0; cr__addr = 0; cr__data_in = 0; o_wait = 0;
    @(negedge clk);
    cycle(1, 0, 0, 24'h0, 16'h0);
    chk("rst_addr", addr, 0);
    idle(2);

    // write D00D at 0x1337, count wait-high cycles
    cycle(0, 0, 1, 24'h1337, 16'hD00D);
    chk("wr_addr", addr, 23'h0099B);
    wait_hi = 1;
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 0, 24'h0, 16'h0);
      if (cr__wait) wait_hi++;
    end
    chk("wr_wait_len", wait_hi, 6);

    // read back
    cycle(0, 1, 0, 24'h1337, 16'h0);
    wait_hi = 1;
    for (int i = 0; i < 6; i++) begin
      cycle(0, 0, 0, 24'h0, 16'h0);
      if (cr__wait) wait_hi++;
    end
    chk("rd_wait_len", wait_hi, 5);
    chk("rd_data", cr__data_out, 16'hD00D);

    // read pulsed during a write is dropped
    cycle(0, 0, 1, 24'h0040, 16'h1234);
    cycle(0, 0, 0, 24'h0, 16'h0);
    cycle(0, 1, 0, 24'h1337, 16'h0);
    idle(6);
    chk("drop_dout", cr__data_out, 16'hD00D);
    chk("drop_ce", ce_falls, accepts);

    // simultaneous read+write performs the write
    cycle(0, 1, 1, 24'h0022, 16'hBEEF);
    chk("sim_we", we_n, 0);
    idle(7);
    cycle(0, 1, 0, 24'h0022, 16'h0);
    idle(6);
    chk("sim_data", cr__data_out, 16'hBEEF);

    // reset in the middle of a write
    cycle(0, 0, 1, 24'h0100, 16'h5A5A);
    idle(1);
    cycle(1, 0, 0, 24'h0, 16'h0);
    chk("mid_rst_wait", cr__wait, 0);
    idle(2);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      bit rst, rd, wr;
      logic [23:0] a;
      rst = ($urandom_range(0, 99) == 0);
      rd  = ($urandom_range(0, 3) == 0);
      wr  = ($urandom_range(0, 3) == 0);
      a   = {15'h0, 9'($urandom)};
      cycle(rst, rd, wr, a, 16'($urandom));
    end
    idle(8);
    chk("ce_count", ce_falls, accepts);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
